// File: rtl/stream_demux_1_4.sv
// 1:4 valid/ready stream demultiplexer. Each destination lane has its own 2-entry FIFO
// and a wrapping count of delivered words.
module stream_demux_1_4 #(
   parameter int unsigned W  = 4,
   parameter int unsigned CW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    in_data,
   input  logic [1:0]      in_sel,
   output logic [3:0]      out_valid,
   input  logic [3:0]      out_ready,
   output logic [4*W-1:0]  out_data,
   output logic [4*CW-1:0] out_count
);

   logic [W-1:0]  mem_q [4][2];
   logic [3:0]    rd_q;
   logic [3:0]    wr_q;
   logic [1:0]    occ_q [4];
   logic [CW-1:0] cnt_q [4];

   logic [3:0] full;
   logic [3:0] push;
   logic [3:0] pop;

   always_comb begin
      full      = '0;
      out_valid = '0;
      out_data  = '0;
      out_count = '0;
      for (int k = 0; k < 4; k++) begin
         full[k]               = (occ_q[k] == 2'd2);
         out_valid[k]          = (occ_q[k] != 2'd0);
         out_data[k*W +: W]    = mem_q[k][rd_q[k]];
         out_count[k*CW +: CW] = cnt_q[k];
      end
   end

   // Only the selected lane's full flag gates the input: head-of-line blocking is intended.
   assign in_ready = ~full[in_sel];

   always_comb begin
      push = '0;
      pop  = '0;
      for (int k = 0; k < 4; k++) begin
         push[k] = in_valid & in_ready & (in_sel == 2'(k));
         pop[k]  = out_valid[k] & out_ready[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q <= '0;
         wr_q <= '0;
         for (int k = 0; k < 4; k++) begin
            occ_q[k] <= 2'd0;
            cnt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (push[k]) begin
               wr_q[k] <= ~wr_q[k];
            end
            if (pop[k]) begin
               rd_q[k]  <= ~rd_q[k];
               cnt_q[k] <= cnt_q[k] + CW'(1);
            end
            unique case ({push[k], pop[k]})
               2'b10:   occ_q[k] <= occ_q[k] + 2'd1;
               2'b01:   occ_q[k] <= occ_q[k] - 2'd1;
               default: occ_q[k] <= occ_q[k];
            endcase
         end
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (push[k]) begin
            mem_q[k][wr_q[k]] <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Randomized + directed bench for stream_demux_1_4: per-lane queue model with a
// scoreboard monitor that checks every lane, handshake and counter each cycle.
module tb_stream_demux_1_4;
   localparam int unsigned W  = 4;
   localparam int unsigned CW = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [W-1:0]    in_data = '0;
   logic [1:0]      in_sel = '0;
   logic [3:0]      out_valid;
   logic [3:0]      out_ready = '0;
   logic [4*W-1:0]  out_data;
   logic [4*CW-1:0] out_count;

   stream_demux_1_4 #(.W(W), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   // Reference model: each lane is simply the list of words accepted but not yet delivered.
   logic [W-1:0] q [4][$];
   int           mcnt [4];
   int           tests = 0;
   int           fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: runs 1 time unit after each falling edge, on the state that the next
   // rising edge will act on.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            chk($sformatf("in_ready sel%0d", in_sel), {63'd0, in_ready},
                {63'd0, q[in_sel].size() < 2});
            for (int k = 0; k < 4; k++) begin
               chk($sformatf("out_count%0d", k), {{(64-CW){1'b0}}, out_count[k*CW +: CW]},
                   {{(64-CW){1'b0}}, CW'(mcnt[k])});
               chk($sformatf("out_valid%0d", k), {63'd0, out_valid[k]},
                   {63'd0, q[k].size() != 0});
               if (q[k].size() != 0) begin
                  chk($sformatf("out_data%0d", k), {{(64-W){1'b0}}, out_data[k*W +: W]},
                      {{(64-W){1'b0}}, q[k][0]});
                  if (out_ready[k]) begin
                     void'(q[k].pop_front());
                     mcnt[k]++;
                  end
               end
            end
         end
      end
   end

   // One cycle of stimulus; accepted words enter the model after the monitor has run.
   task automatic cycle(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                        input logic [3:0] r, output logic acc);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      @(negedge clk);
      #3;
      acc = v & in_ready;
      if (acc) q[s].push_back(d);
   endtask

   task automatic idle(input logic [3:0] r);
      logic a;
      cycle(1'b0, 2'd0, '0, r, a);
   endtask

   task automatic send(input logic [1:0] s, input logic [W-1:0] d, input logic [3:0] r);
      logic a;
      a = 1'b0;
      for (int i = 0; i < 20 && !a; i++) cycle(1'b1, s, d, r, a);
      if (!a) chk("send timeout", 64'd0, 64'd1);
   endtask

   task automatic do_reset();
      idle(4'b0000);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("rst out_valid", {60'd0, out_valid}, 64'd0);
      chk("rst in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst out_count", {{(64-4*CW){1'b0}}, out_count}, 64'd0);
      for (int k = 0; k < 4; k++) begin
         q[k].delete();
         mcnt[k] = 0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic          acc;
   logic [CW-1:0] c0;

   initial begin
      for (int k = 0; k < 4; k++) mcnt[k] = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      do_reset();
      repeat (3) idle(4'b0000);

      // Steering
      send(2'd2, 4'hA, 4'b1111);
      send(2'd0, 4'h3, 4'b1111);
      send(2'd3, 4'hF, 4'b1111);
      repeat (3) idle(4'b1111);
      chk("steer counts", {{(64-4*CW){1'b0}}, out_count},
          {32'd0, 8'd1, 8'd1, 8'd0, 8'd1});

      // Full / backpressure on lane 1
      cycle(1'b1, 2'd1, 4'h1, 4'b1101, acc);
      chk("full acc1", {63'd0, acc}, 64'd1);
      cycle(1'b1, 2'd1, 4'h2, 4'b1101, acc);
      chk("full acc2", {63'd0, acc}, 64'd1);
      cycle(1'b1, 2'd1, 4'h3, 4'b1101, acc);
      chk("full acc3 blocked", {63'd0, acc}, 64'd0);
      send(2'd1, 4'h3, 4'b1111);
      repeat (4) idle(4'b1111);

      // Head-of-line blocking: lane 0 word waits behind a blocked lane 1 word
      send(2'd1, 4'h5, 4'b1101);
      send(2'd1, 4'h6, 4'b1101);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 2'd1, 4'h7, 4'b1101, acc);
         chk("hol blocked", {63'd0, acc}, 64'd0);
         chk("hol lane0 empty", {63'd0, out_valid[0]}, 64'd0);
      end
      send(2'd1, 4'h7, 4'b1111);
      send(2'd0, 4'h8, 4'b1111);
      repeat (4) idle(4'b1111);

      // Simultaneous push/pop on lane 2 at occupancy 1
      c0 = out_count[2*CW +: CW];
      send(2'd2, 4'h9, 4'b1011);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 2'd2, W'(i), 4'b1111, acc);
         chk("pushpop acc", {63'd0, acc}, 64'd1);
      end
      idle(4'b1011);
      chk("pushpop count", {{(64-CW){1'b0}}, out_count[2*CW +: CW] - c0}, 64'd10);
      chk("pushpop occ1", {63'd0, out_valid[2]}, 64'd1);
      repeat (3) idle(4'b1111);

      // Counter wrap on lane 3, then reset with words buffered
      do_reset();
      for (int i = 0; i < 257; i++) send(2'd3, W'($urandom), 4'b1111);
      repeat (3) idle(4'b1111);
      chk("wrap count3", {{(64-CW){1'b0}}, out_count[3*CW +: CW]}, 64'd1);
      send(2'd3, 4'hC, 4'b0111);
      send(2'd3, 4'hD, 4'b0111);
      do_reset();
      idle(4'b1111);
      chk("post rst valid", {60'd0, out_valid}, 64'd0);
      chk("post rst count3", {{(64-CW){1'b0}}, out_count[3*CW +: CW]}, 64'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), W'($urandom),
               4'($urandom), acc);
      end
      repeat (6) idle(4'b1111);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
